// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : 8N1 UART transmitter with a one-entry holding register so the
//             next byte can be queued while the current frame is on the wire.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int unsigned clk_per_bit_p = 10416
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tx_v_i,
    input  logic [7:0] tx_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       tx_busy_o
);

    localparam logic [2:0]  c_e_reset     = 3'd0;
    localparam logic [2:0]  c_e_idle      = 3'd1;
    localparam logic [2:0]  c_e_start_bit = 3'd2;
    localparam logic [2:0]  c_e_data_bits = 3'd3;
    localparam logic [2:0]  c_e_stop_bit  = 3'd4;
    localparam logic [15:0] c_last_cnt    = 16'(clk_per_bit_p - 1);

    logic [2:0]  r_state,    w_state_n;
    logic [15:0] r_clk_cnt,  w_clk_cnt_n;
    logic [2:0]  r_data_cnt, w_data_cnt_n;
    logic [7:0]  r_shift,    w_shift_n;
    logic [7:0]  r_hold,     w_hold_n;
    logic        r_hold_v,   w_hold_v_n;
    logic        r_tx,       w_tx_n;

    logic        w_accept;
    logic        w_bit_done;
    logic [2:0]  w_next_idx;

    // Ready depends on registers only, so the host sees no path from tx_v_i.
    assign tx_ready_o = !r_hold_v && (r_state != c_e_reset);
    assign tx_busy_o  = r_hold_v || (r_state == c_e_start_bit) ||
                        (r_state == c_e_data_bits) || (r_state == c_e_stop_bit);
    assign tx_o       = r_tx;

    assign w_accept   = tx_v_i && tx_ready_o;
    assign w_bit_done = (r_clk_cnt == c_last_cnt);
    assign w_next_idx = r_data_cnt + 3'd1;

    always_comb begin
        w_state_n    = r_state;
        w_clk_cnt_n  = r_clk_cnt;
        w_data_cnt_n = r_data_cnt;
        w_shift_n    = r_shift;
        w_hold_n     = r_hold;
        w_hold_v_n   = r_hold_v;
        w_tx_n       = r_tx;

        if (w_accept) begin
            w_hold_n   = tx_i;
            w_hold_v_n = 1'b1;
        end

        case (r_state)
            c_e_reset: begin
                w_state_n    = c_e_idle;
                w_tx_n       = 1'b1;
                w_clk_cnt_n  = 16'd0;
                w_data_cnt_n = 3'd0;
            end
            c_e_idle: begin
                w_tx_n       = 1'b1;
                w_clk_cnt_n  = 16'd0;
                w_data_cnt_n = 3'd0;
                if (r_hold_v) begin
                    w_shift_n  = r_hold;
                    w_hold_v_n = 1'b0;
                    w_tx_n     = 1'b0;
                    w_state_n  = c_e_start_bit;
                end
            end
            c_e_start_bit: begin
                if (w_bit_done) begin
                    w_clk_cnt_n  = 16'd0;
                    w_tx_n       = r_shift[0];
                    w_data_cnt_n = 3'd0;
                    w_state_n    = c_e_data_bits;
                end else begin
                    w_clk_cnt_n = r_clk_cnt + 16'd1;
                end
            end
            c_e_data_bits: begin
                if (w_bit_done) begin
                    w_clk_cnt_n = 16'd0;
                    if (r_data_cnt != 3'd7) begin
                        w_data_cnt_n = w_next_idx;
                        w_tx_n       = r_shift[w_next_idx];
                    end else begin
                        w_tx_n    = 1'b1;
                        w_state_n = c_e_stop_bit;
                    end
                end else begin
                    w_clk_cnt_n = r_clk_cnt + 16'd1;
                end
            end
            c_e_stop_bit: begin
                if (w_bit_done) begin
                    w_clk_cnt_n = 16'd0;
                    // A queued byte starts immediately, with no idle gap.
                    if (r_hold_v) begin
                        w_shift_n  = r_hold;
                        w_hold_v_n = 1'b0;
                        w_tx_n     = 1'b0;
                        w_state_n  = c_e_start_bit;
                    end else begin
                        w_state_n = c_e_idle;
                    end
                end else begin
                    w_clk_cnt_n = r_clk_cnt + 16'd1;
                end
            end
            default: begin
                w_state_n = c_e_reset;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= c_e_reset;
            r_clk_cnt  <= 16'd0;
            r_data_cnt <= 3'd0;
            r_shift    <= 8'd0;
            r_hold     <= 8'd0;
            r_hold_v   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_clk_cnt  <= w_clk_cnt_n;
            r_data_cnt <= w_data_cnt_n;
            r_shift    <= w_shift_n;
            r_hold     <= w_hold_n;
            r_hold_v   <= w_hold_v_n;
            r_tx       <= w_tx_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx at three bit-period settings.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, v4, rdy4, tx4, busy4;
    logic [7:0] d4;
    logic       rst16, v16, rdy16, tx16, busy16;
    logic [7:0] d16;
    logic       rstd, vd, rdyd, txd, busyd;
    logic [7:0] dd;

    uart_tx #(.clk_per_bit_p(4)) u_dut4 (
        .clk_i(clk), .reset_i(rst4), .tx_v_i(v4), .tx_i(d4),
        .tx_ready_o(rdy4), .tx_o(tx4), .tx_busy_o(busy4));

    uart_tx #(.clk_per_bit_p(16)) u_dut16 (
        .clk_i(clk), .reset_i(rst16), .tx_v_i(v16), .tx_i(d16),
        .tx_ready_o(rdy16), .tx_o(tx16), .tx_busy_o(busy16));

    uart_tx u_dutd (
        .clk_i(clk), .reset_i(rstd), .tx_v_i(vd), .tx_i(dd),
        .tx_ready_o(rdyd), .tx_o(txd), .tx_busy_o(busyd));

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // wire bits in transmit order, bit 0 first
    } vec_t;

    vec_t vecs [6];

    logic [7:0] exp_q [$];
    logic       rx_en = 1'b0;
    int         rx_count = 0;
    logic [7:0] rx_byte;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic send_single(input vec_t v);
        chk("single_ready_pre", rdy4, 1);
        chk("single_busy_pre", busy4, 0);
        v4 = 1'b1;
        d4 = v.data;
        step();
        v4 = 1'b0;
        d4 = ~v.data;
        chk("single_ready_t1", rdy4, 0);
        chk("single_tx_t1", tx4, 1);
        chk("single_busy_t1", busy4, 1);
        step();
        chk("single_ready_t2", rdy4, 1);
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("single_%02h_tx_c%0d", v.data, k), tx4, v.frame[k / 4]);
            chk("single_busy_frame", busy4, 1);
            step();
        end
        chk("single_tx_after", tx4, 1);
        chk("single_busy_after", busy4, 0);
    endtask

    // Back-to-back frames with junk data offered while the holding register is full.
    task automatic back_to_back();
        logic [9:0] f0, f1;
        logic       exp_tx;
        f0 = frame_of(8'h00);
        f1 = frame_of(8'hFF);
        v4 = 1'b1;
        d4 = 8'h00;
        step();
        chk("b2b_ready_a1", rdy4, 0);
        d4 = 8'hFF;
        step();
        for (int k = 0; k < 82; k++) begin
            if (k < 40)      exp_tx = f0[k / 4];
            else if (k < 80) exp_tx = f1[(k - 40) / 4];
            else             exp_tx = 1'b1;
            chk($sformatf("b2b_tx_c%0d", k), tx4, exp_tx);
            chk($sformatf("b2b_ready_c%0d", k), rdy4, (k == 0 || k >= 40));
            chk($sformatf("b2b_busy_c%0d", k), busy4, (k < 80));
            if (k >= 1 && k <= 38) begin
                v4 = 1'b1;
                d4 = 8'($urandom);
            end else if (k > 38) begin
                v4 = 1'b0;
            end
            step();
        end
    endtask

    task automatic backpressure();
        logic [7:0] bp [3];
        logic       wave [170];
        logic       busy_w [170];
        logic [7:0] got;
        int         idx, base, ones;
        bp[0] = 8'h11; bp[1] = 8'hC3; bp[2] = 8'h7E;
        idx = 0;
        for (int c = 0; c < 170; c++) begin
            wave[c]   = tx4;
            busy_w[c] = busy4;
            if (idx < 3) begin
                v4 = 1'b1;
                d4 = bp[idx];
                if (rdy4) idx++;
            end else begin
                v4 = 1'b0;
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            base = 2 + 40 * i;
            chk($sformatf("bp_start_%0d", i), wave[base + 2], 0);
            for (int j = 0; j < 8; j++) got[j] = wave[base + 4 + 4 * j + 2];
            chk($sformatf("bp_byte_%0d", i), got, bp[i]);
            chk($sformatf("bp_stop_%0d", i), wave[base + 38], 1);
        end
        ones = 0;
        for (int c = 122; c < 170; c++) ones += (wave[c] && !busy_w[c]) ? 1 : 0;
        chk("bp_no_extra_frame", ones, 48);
    endtask

    task automatic reset_mid_frame();
        int idle_ok;
        vd = 1'b1;
        dd = 8'h5A;
        step();
        vd = 1'b0;
        dd = 8'h00;
        step();
        chk("rst_ready_t2", rdyd, 1);
        vd = 1'b1;
        dd = 8'hC7;
        step();
        vd = 1'b0;
        chk("rst_held_ready", rdyd, 0);
        repeat (15000) step();
        chk("rst_pre_tx_bit0", txd, 0);
        chk("rst_pre_busy", busyd, 1);
        rstd = 1'b1;
        step();
        rstd = 1'b0;
        chk("rst_tx_next", txd, 1);
        chk("rst_ready_next", rdyd, 0);
        chk("rst_busy_next", busyd, 0);
        step();
        chk("rst_ready_after", rdyd, 1);
        idle_ok = 0;
        for (int c = 0; c < 100; c++) begin
            idle_ok += (txd === 1'b1 && busyd === 1'b0) ? 1 : 0;
            step();
        end
        chk("rst_held_byte_lost", idle_ok, 100);
    endtask

    task automatic loopback();
        logic [7:0] b;
        logic       xfer;
        int         budget, gap;
        rx_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            b   = 8'($urandom);
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : 0;
            v16 = 1'b0;
            repeat (gap) step();
            v16    = 1'b1;
            xfer   = 1'b0;
            budget = 0;
            while (!xfer && budget < 400) begin
                if (rdy16) begin
                    d16  = b;
                    xfer = 1'b1;
                    exp_q.push_back(b);
                end else begin
                    d16 = 8'($urandom);
                end
                step();
                budget++;
            end
            if (!xfer) begin
                n_checks++;
                n_errors++;
                $display("FAIL loopback_handshake: byte %0d not accepted within 400 cycles", i);
                break;
            end
        end
        v16 = 1'b0;
        budget = 0;
        while (rx_count < 256 && budget < 2000) begin
            step();
            budget++;
        end
        chk("loopback_rx_count", rx_count, 256);
        chk("loopback_queue_empty", exp_q.size(), 0);
        rx_en = 1'b0;
    endtask

    // Reference receiver: find the start edge, then sample each bit at mid-period.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_en && tx16 === 1'b0) begin
                repeat (7) @(posedge clk);
                #1;
                chk("rx_start_bit", tx16, 0);
                for (int j = 0; j < 8; j++) begin
                    repeat (16) @(posedge clk);
                    #1;
                    rx_byte[j] = tx16;
                end
                repeat (16) @(posedge clk);
                #1;
                chk("rx_stop_bit", tx16, 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: got %02h expected no frame", rx_byte);
                end else begin
                    chk("rx_byte", rx_byte, exp_q.pop_front());
                end
                rx_count++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h01, 10'h202};
        vecs[4] = '{8'h80, 10'h300};
        vecs[5] = '{8'h3C, 10'h278};

        rst4 = 1'b1; rst16 = 1'b1; rstd = 1'b1;
        v4 = 1'b0; v16 = 1'b0; vd = 1'b0;
        d4 = 8'h00; d16 = 8'h00; dd = 8'h00;
        step();
        step();
        chk("reset_tx", tx4, 1);
        chk("reset_ready", rdy4, 0);
        chk("reset_busy", busy4, 0);
        chk("reset_tx_d", txd, 1);
        rst4 = 1'b0; rst16 = 1'b0; rstd = 1'b0;
        chk("reset_state_ready", rdy4, 0);
        step();
        chk("post_reset_ready", rdy4, 1);
        chk("post_reset_ready16", rdy16, 1);
        chk("post_reset_tx", tx4, 1);

        for (int i = 0; i < 6; i++) send_single(vecs[i]);
        back_to_back();
        backpressure();
        reset_mid_frame();
        loopback();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter (1 start bit, 8 data bits LSB first, 1 stop bit, no parity), the transmit-side counterpart of the board UART receiver.
- Accepts bytes over a valid/ready handshake into a one-entry holding register, so the next byte can be queued while the current frame is on the wire.
- Sits between the host-side debug/loader logic and the FPGA UART TX pin; 100 MHz clock, 9600 baud by default.

Parameters:
- clk_per_bit_p, 10416, clock cycles per bit period (100 MHz / 9600 baud). Legal range 2..65535; the bit counter is 16 bits.

Ports:
- clk_i  input  1  system clock, all logic on posedge
- reset_i  input  1  synchronous, active-high reset
- tx_v_i  input  1  byte valid
- tx_i  input  8  byte to send; bit 0 goes on the wire first
- tx_ready_o  output  1  holding register empty; a transfer occurs when tx_v_i & tx_ready_o
- tx_o  output  1  serial line, registered, idle high
- tx_busy_o  output  1  a frame is in progress or a byte is held

Behaviour:
- Single clock domain; reset is synchronous and active-high on clk_i/reset_i.
- Reset values: tx_o=1, tx_ready_o=0, tx_busy_o=0. The holding register, shift register, counters and state all clear. State is e_reset.
- tx_o is driven only from a flop; there are no glitches on the pin.
- tx_ready_o = !hold_v_r && state!=e_reset. It comes from registers only, with no combinational path from tx_v_i.
- Handshake:
  - On the transfer cycle, tx_i is captured into the holding register and hold_v_r is set.
  - tx_i and tx_v_i are ignored when tx_ready_o=0.
  - tx_v_i may drop without a transfer.
- States:
  - e_reset: the cycle after reset goes to e_idle.
  - e_idle: tx_o=1, counters 0. If hold_v_r, move the holding register into the shift register, clear hold_v_r, drive tx_o=0, clk_cnt=0, and go to e_start_bit.
  - e_start_bit: when clk_cnt==clk_per_bit_p-1, set clk_cnt=0, drive tx_o=shift[0], data_cnt=0, and go to e_data_bits. Otherwise clk_cnt+1.
  - e_data_bits: when clk_cnt==clk_per_bit_p-1, set clk_cnt=0. If data_cnt<7, data_cnt+1 and tx_o=shift[data_cnt+1]. Else tx_o=1 and go to e_stop_bit. Otherwise clk_cnt+1.
  - e_stop_bit: when clk_cnt==clk_per_bit_p-1, set clk_cnt=0. If hold_v_r, load it as in e_idle: tx_o=0, go to e_start_bit, with no idle gap. Else go to e_idle. Otherwise clk_cnt+1.
  - Any illegal encoding goes to e_reset.
- Timing:
  - Each of the 10 bits is held exactly clk_per_bit_p cycles.
  - Latency: handshake in cycle T puts the start bit on tx_o from cycle T+2 when idle.
  - Back-to-back frames are exactly 10*clk_per_bit_p cycles apart.
- tx_busy_o = hold_v_r || state in {e_start_bit, e_data_bits, e_stop_bit}.
- The holding register refills at the earliest in the cycle after it is emptied. There is no simultaneous load and accept, because tx_ready_o is registered state.
- Reset mid-frame: tx_o returns to 1 on the next cycle, the frame is truncated, and the held byte is discarded.
- tx_i is sampled only on the transfer cycle; later changes do not affect the frame.

Test Plan:
- Single byte, clk_per_bit_p=4: transfer 8'hA5 at cycle T -> tx_o low from T+2 for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles. tx_busy_o deasserts after the stop bit; tx_ready_o is high again at T+2.
- Back-to-back, clk_per_bit_p=4: send 8'h00 then immediately 8'hFF -> second start bit follows the first stop bit with no gap; frames are 40 cycles apart. tx_ready_o is low from the second transfer until the second frame loads.
- Backpressure: hold tx_v_i=1 with 3 distinct bytes -> exactly 3 frames, in order, no byte duplicated or dropped. The receiver model decodes 3 matching bytes.
- Ignored input: tx_v_i=1 while tx_ready_o=0 with changing tx_i -> no capture; the frame content equals the originally accepted byte.
- Reset mid-data-bit (default clk_per_bit_p): assert reset_i for 1 cycle -> tx_o=1 next cycle, tx_ready_o=0 for one cycle then 1, tx_busy_o=0, held byte lost.
- Loopback: drive tx_o into the board UART receiver with clk_per_bit_p=16 and 256 random bytes -> every byte received intact.
